// File: rtl/mips_lsu_pkg.sv
// mips_lsu shared opcodes, FSM state type and word width.
// Optional alignment trapping: define MIPS_LSU_ALIGN_TRAP_EN.
package mips_lsu_pkg;
  localparam int WORD_W = 32;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_ST,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  function automatic logic is_load(
    input logic [5:0] op
  );
    return op == OP_LB || op == OP_LH ||
           op == OP_LW || op == OP_LBU ||
           op == OP_LHU;
  endfunction

  function automatic logic is_store(
    input logic [5:0] op
  );
    return op == OP_SB || op == OP_SH ||
           op == OP_SW;
  endfunction
endpackage

// File: rtl/mips_lsu_lane.sv
// mips_lsu lane logic: little-endian load extract/extend, store merge.
// Optional alignment trapping lives in mips_lsu (MIPS_LSU_ALIGN_TRAP_EN).
module mips_lsu_lane
  import mips_lsu_pkg::*;
(
  input  logic [5:0]        op,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] ld_data,
  output logic [WORD_W-1:0] st_data
);
  logic [WORD_W-1:0] bsh;
  logic [7:0]        b;
  logic [15:0]       h;
  logic [4:0]        bamt;
  logic [4:0]        hamt;
  logic [WORD_W-1:0] bmask;
  logic [WORD_W-1:0] hmask;

  always_comb begin
    bamt  = {lane, 3'b000};
    hamt  = {lane[1], 4'b0000};
    bsh   = rdata >> bamt;
    b     = bsh[7:0];
    h     = lane[1] ? rdata[31:16] : rdata[15:0];
    bmask = 32'h0000_00FF << bamt;
    hmask = 32'h0000_FFFF << hamt;
  end

  always_comb begin
    ld_data = rdata;
    unique case (1'b1)
      op == OP_LB:  ld_data = {{24{b[7]}}, b};
      op == OP_LBU: ld_data = {24'h0, b};
      op == OP_LH:  ld_data = {{16{h[15]}}, h};
      op == OP_LHU: ld_data = {16'h0, h};
      default:      ld_data = rdata;
    endcase
  end

  always_comb begin
    st_data = word;
    unique case (1'b1)
      op == OP_SB:
        st_data = (word & ~bmask) |
                  ((32'(wdata[7:0]) << bamt) & bmask);
      op == OP_SH:
        st_data = (word & ~hmask) |
                  ((32'(wdata[15:0]) << hamt) & hmask);
      op == OP_SW:  st_data = wdata;
      default:      st_data = word;
    endcase
  end
endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: MEM-stage load/store unit with sub-word read-modify-write.
// Define MIPS_LSU_ALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module mips_lsu
  import mips_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);
  state_t            state_q, state_d;
  logic [5:0]        op_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] rdata_q;
  logic              fault_q;
  logic              accept;
  logic              req_fault;
  logic [WORD_W-1:0] ld_data;
  logic [WORD_W-1:0] st_data;
  logic              word_acc;

  assign accept = req_valid && (state_q == S_IDLE);

  always_comb begin
    req_fault = !(is_load(req_op) || is_store(req_op));
`ifdef MIPS_LSU_ALIGN_TRAP_EN
    if ((req_op == OP_LH || req_op == OP_LHU ||
         req_op == OP_SH) && req_addr[0])
      req_fault = 1'b1;
    if ((req_op == OP_LW || req_op == OP_SW) &&
        req_addr[1:0] != 2'b00)
      req_fault = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            req_fault:        state_d = S_RESP;
            is_load(req_op):  state_d = S_LD;
            req_op == OP_SW:  state_d = S_ST;
            default:          state_d = S_RMW_RD;
          endcase
        end
      end
      S_LD:     state_d = S_RESP;
      S_ST:     state_d = S_RESP;
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        fault_q <= req_fault;
        rdata_q <= '0;
      end
      if (state_q == S_LD)     rdata_q <= ld_data;
      if (state_q == S_RMW_RD) word_q  <= mem_rdata;
    end
  end

  mips_lsu_lane u_lane (
    .op      (op_q),
    .lane    (addr_q[1:0]),
    .rdata   (mem_rdata),
    .wdata   (wdata_q),
    .word    (word_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  // Memory side decodes only from registered state so nothing glitches into
  // the level-sensitive write port.
  always_comb begin
    word_acc  = (op_q == OP_LW) || (op_q == OP_SW);
    mem_read  = (state_q == S_LD) || (state_q == S_RMW_RD);
    mem_write = (state_q == S_ST) || (state_q == S_RMW_WR);
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_read || mem_write)
      mem_addr = word_acc ? addr_q : {addr_q[31:2], 2'b00};
    if (mem_write)
      mem_wdata = st_data;
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_fault = rsp_valid && fault_q;
endmodule

// File: tb/tb_mips_lsu.sv
// Directed self-checking bench for mips_lsu with a byte-array memory.
// Honours MIPS_LSU_ALIGN_TRAP_EN for the misaligned SW case.
module tb_mips_lsu;
  import mips_lsu_pkg::*;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic [5:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int assertions = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_lsu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [7:0]  mem [0:255];
  logic        pre_we = 0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [7:0]  ra;

  always_comb begin
    ra = mem_addr[7:0];
    mem_rdata = {mem[ra + 8'd3], mem[ra + 8'd2],
                 mem[ra + 8'd1], mem[ra]};
  end

  always @(posedge clk) begin
    if (pre_we) begin
      for (int i = 0; i < 4; i++)
        mem[pre_addr + 8'(i)] <= pre_data[8*i +: 8];
    end else if (mem_write) begin
      for (int i = 0; i < 4; i++)
        mem[mem_addr[7:0] + 8'(i)] <= mem_wdata[8*i +: 8];
    end
  end

  logic        lg_read  [1:8];
  logic        lg_write [1:8];
  logic        lg_ready [1:8];
  logic [31:0] lg_addr  [1:8];
  logic [31:0] lg_wdata [1:8];
  int          lat;
  int          nrsp;
  int          nwrite;
  logic [31:0] r_rdata;
  logic        r_fault;

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 0;
  endtask

  task automatic do_req(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = d; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0; req_op = '0; req_addr = '0; req_wdata = '0;
    lat = 0; nrsp = 0; nwrite = 0; r_rdata = 'x; r_fault = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      lg_read[k]  = mem_read;
      lg_write[k] = mem_write;
      lg_ready[k] = req_ready;
      lg_addr[k]  = mem_addr;
      lg_wdata[k] = mem_wdata;
      if (mem_write) nwrite++;
      if (rsp_valid) begin
        nrsp++;
        if (lat == 0) begin
          lat = k; r_rdata = rsp_rdata; r_fault = rsp_fault;
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    assertions++;
    if ({req_ready, rsp_valid, rsp_fault, mem_read, mem_write} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctl: got %b expected 10000",
               {req_ready, rsp_valid, rsp_fault, mem_read, mem_write});
    end
    assertions++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data: got %h %h %h expected 0",
               rsp_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_loads;
    do_req(OP_LB, 32'h11, 32'h0);
    assertions++;
    if (lat !== 2 || r_rdata !== 32'hFFFFFFAA || r_fault !== 1'b0) begin
      failures++;
      $display("FAIL lb: got lat %0d data %h flt %b expected 2 ffffffaa 0",
               lat, r_rdata, r_fault);
    end
    assertions++;
    if (nwrite !== 0 || lg_read[1] !== 1'b1 || lg_addr[1] !== 32'h10) begin
      failures++;
      $display("FAIL lb_bus: got wr %0d rd %b addr %h expected 0 1 10",
               nwrite, lg_read[1], lg_addr[1]);
    end
    do_req(OP_LHU, 32'h12, 32'h0);
    assertions++;
    if (lat !== 2 || r_rdata !== 32'h00008899) begin
      failures++;
      $display("FAIL lhu: got lat %0d data %h expected 2 00008899",
               lat, r_rdata);
    end
    do_req(OP_LH, 32'h12, 32'h0);
    assertions++;
    if (lat !== 2 || r_rdata !== 32'hFFFF8899) begin
      failures++;
      $display("FAIL lh: got lat %0d data %h expected 2 ffff8899",
               lat, r_rdata);
    end
    do_req(OP_LBU, 32'h10, 32'h0);
    assertions++;
    if (lat !== 2 || r_rdata !== 32'h000000BB) begin
      failures++;
      $display("FAIL lbu: got lat %0d data %h expected 2 000000bb",
               lat, r_rdata);
    end
  endtask

  task automatic test_sb;
    do_req(OP_SB, 32'h13, 32'h12345677);
    assertions++;
    if (lg_read[1] !== 1'b1 || lg_write[1] !== 1'b0 ||
        lg_addr[1] !== 32'h10) begin
      failures++;
      $display("FAIL sb_rd: got rd %b wr %b addr %h expected 1 0 10",
               lg_read[1], lg_write[1], lg_addr[1]);
    end
    assertions++;
    if (lg_write[2] !== 1'b1 || lg_read[2] !== 1'b0 ||
        lg_wdata[2] !== 32'h7799AABB || lg_addr[2] !== 32'h10) begin
      failures++;
      $display("FAIL sb_wr: got wr %b rd %b data %h addr %h expected 1 0 7799aabb 10",
               lg_write[2], lg_read[2], lg_wdata[2], lg_addr[2]);
    end
    assertions++;
    if (lat !== 3 || nrsp !== 1 || r_rdata !== 32'h0 || nwrite !== 1) begin
      failures++;
      $display("FAIL sb_rsp: got lat %0d n %0d data %h wr %0d expected 3 1 0 1",
               lat, nrsp, r_rdata, nwrite);
    end
  endtask

  task automatic test_sw_lw;
    do_req(OP_SW, 32'h20, 32'hDEADBEEF);
    assertions++;
    if (lat !== 2 || lg_write[1] !== 1'b1 || lg_wdata[1] !== 32'hDEADBEEF ||
        lg_addr[1] !== 32'h20) begin
      failures++;
      $display("FAIL sw: got lat %0d wr %b data %h addr %h expected 2 1 deadbeef 20",
               lat, lg_write[1], lg_wdata[1], lg_addr[1]);
    end
    assertions++;
    if ({lg_ready[1], lg_ready[2], lg_ready[3]} !== 3'b001) begin
      failures++;
      $display("FAIL sw_ready: got %b expected 001",
               {lg_ready[1], lg_ready[2], lg_ready[3]});
    end
    do_req(OP_LW, 32'h20, 32'h0);
    assertions++;
    if (lat !== 2 || r_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL lw: got lat %0d data %h expected 2 deadbeef",
               lat, r_rdata);
    end
    assertions++;
    if ({lg_ready[1], lg_ready[2], lg_ready[3]} !== 3'b001) begin
      failures++;
      $display("FAIL lw_ready: got %b expected 001",
               {lg_ready[1], lg_ready[2], lg_ready[3]});
    end
  endtask

  task automatic test_sh;
    do_req(OP_SH, 32'h22, 32'hCAFE1234);
    assertions++;
    if (lat !== 3 || lg_wdata[2] !== 32'h1234BEEF || lg_addr[2] !== 32'h20) begin
      failures++;
      $display("FAIL sh: got lat %0d data %h addr %h expected 3 1234beef 20",
               lat, lg_wdata[2], lg_addr[2]);
    end
  endtask

  task automatic test_faults;
    do_req(6'h3F, 32'h10, 32'h0);
    assertions++;
    if (lat !== 1 || r_fault !== 1'b1 || r_rdata !== 32'h0 ||
        nwrite !== 0 || lg_read[1] !== 1'b0) begin
      failures++;
      $display("FAIL badop: got lat %0d flt %b data %h wr %0d rd %b expected 1 1 0 0 0",
               lat, r_fault, r_rdata, nwrite, lg_read[1]);
    end
    do_req(OP_SW, 32'h22, 32'hDEADBEEF);
`ifdef MIPS_LSU_ALIGN_TRAP_EN
    assertions++;
    if (lat !== 1 || r_fault !== 1'b1 || nwrite !== 0) begin
      failures++;
      $display("FAIL sw_unal: got lat %0d flt %b wr %0d expected 1 1 0",
               lat, r_fault, nwrite);
    end
`else
    assertions++;
    if (lat !== 2 || r_fault !== 1'b0 || lg_addr[1] !== 32'h22) begin
      failures++;
      $display("FAIL sw_unal: got lat %0d flt %b addr %h expected 2 0 22",
               lat, r_fault, lg_addr[1]);
    end
    assertions++;
    if ({mem[8'h25], mem[8'h24], mem[8'h23], mem[8'h22]} !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_unal_mem: got %h expected deadbeef",
               {mem[8'h25], mem[8'h24], mem[8'h23], mem[8'h22]});
    end
`endif
  endtask

  task automatic test_back_to_back;
    int acc [3];
    int nacc;
    int nr;
    nacc = 0; nr = 0;
    acc[0] = -1; acc[1] = -1; acc[2] = -1;
    @(negedge clk);
    req_op = OP_LW; req_addr = 32'h10; req_valid = 1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) begin
        if (nacc < 3) acc[nacc] = i;
        nacc++;
      end
      if (rsp_valid) begin
        nr++;
        assertions++;
        if (rsp_rdata !== 32'h7799AABB) begin
          failures++;
          $display("FAIL b2b_data: got %h expected 7799aabb", rsp_rdata);
        end
      end
    end
    @(posedge clk);
    #1 req_valid = 0;
    repeat (4) @(negedge clk);
    assertions++;
    if (nacc !== 3 || acc[0] !== 0 || acc[1] !== 3 || acc[2] !== 6 || nr !== 2) begin
      failures++;
      $display("FAIL b2b: got n %0d at %0d %0d %0d rsp %0d expected 3 at 0 3 6 rsp 2",
               nacc, acc[0], acc[1], acc[2], nr);
    end
  endtask

  task automatic test_reset_midop;
    int nr;
    nr = 0;
    preload(8'h14, 32'h11223344);
    @(negedge clk);
    req_op = OP_SB; req_addr = 32'h14; req_wdata = 32'h55; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    assertions++;
    if (mem_write !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: got wr %b expected 1", mem_write);
    end
    #1 rst_n = 0;
    #1;
    assertions++;
    if (mem_write !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got wr %b addr %h data %h rdy %b rsp %b expected 0 0 0 1 0",
               mem_write, mem_addr, mem_wdata, req_ready, rsp_valid);
    end
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) nr++;
    end
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) nr++;
    end
    assertions++;
    if (nr !== 0 || req_ready !== 1'b1 || mem[8'h14] !== 8'h44) begin
      failures++;
      $display("FAIL rst_after: got rsp %0d rdy %b byte %h expected 0 1 44",
               nr, req_ready, mem[8'h14]);
    end
  endtask

  initial begin
    test_reset;
    preload(8'h10, 32'h8899AABB);
    @(negedge clk);
    rst_n = 1;
    test_loads;
    test_sb;
    test_sw_lw;
    test_sh;
    test_faults;
    test_back_to_back;
    test_reset_midop;
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mips_lsu.md
# mips_lsu

Load/store unit for the MEM stage of the pipelined MIPS core. It is the initiator toward the byte-addressed, little-endian data memory, whose interface is Address, Memwrite, Memread, WriteData and ReadData, with combinational read and level-sensitive write. It accepts one load or store request at a time from the pipeline and handles the following:
- word accesses;
- sub-word stores, done as a read-modify-write on the containing word;
- sub-word load lane extraction with sign or zero extension.

It returns a one-cycle response and holds `req_ready` low while busy, so the pipeline stalls.

## Interface
- No parameters. Opcodes and widths are fixed in `mips_lsu_pkg`.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — unit idle, request accepted when `req_valid && req_ready`.
- `req_op` in 6 — MIPS major opcode: LB, LH, LW, LBU, LHU, SB, SH or SW.
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data, right-aligned.
- `rsp_valid` out 1 — one-cycle completion pulse.
- `rsp_rdata` out 32 — extended load result; 0 for stores and faults.
- `rsp_fault` out 1 — access faulted; valid with `rsp_valid`.
- `mem_addr` out 32 — to memory `Address`.
- `mem_read` out 1 — to `Memread`.
- `mem_write` out 1 — to `Memwrite`.
- `mem_wdata` out 32 — to `WriteData`.
- `mem_rdata` in 32 — from `ReadData`.

## Operation
- Requests are accepted only in IDLE. `req_addr`, `req_op` and `req_wdata` are latched on acceptance.
- FSM states are IDLE, LD, ST, RMW_RD, RMW_WR and RESP.
  - IDLE → LD for any load.
  - IDLE → ST for SW.
  - IDLE → RMW_RD for SB or SH.
  - IDLE → RESP for a fault.
  - LD → RESP. The extracted result is captured at the end of LD.
  - ST → RESP.
  - RMW_RD → RMW_WR. The full word is captured at the end of RMW_RD.
  - RMW_WR → RESP.
  - RESP → IDLE.
- Word accesses (LW, SW) drive `mem_addr` = latched address.
- Sub-word accesses drive `mem_addr` = `{addr[31:2], 2'b00}`.
- Lanes are little-endian.
  - Byte lane is `addr[1:0]`; lane 0 is bits [7:0].
  - Halfword lane is `addr[1]`; lane 0 is bits [15:0].
- LB and LH sign-extend. LBU and LHU zero-extend.
- RMW_WR drives `mem_wdata` as the captured word with only the target lane replaced by `wdata[7:0]` (SB) or `wdata[15:0]` (SH).
- ST drives `mem_wdata` = `req_wdata`.
- `mem_read` is 1 only in LD and RMW_RD. `mem_write` is 1 only in ST and RMW_WR. The two are never high together.
- `mem_*` outputs decode from the state and latched registers only; there is no combinational path from `req_*`. When not writing, `mem_wdata` is 0, so the level-sensitive memory sees no glitch writes.
- An unsupported `req_op` is accepted and completes with `rsp_fault`=1 and no memory access.

## Timing
- Acceptance in cycle N gives:
  - loads: `rsp_valid` in N+2;
  - SW: `rsp_valid` in N+2;
  - SB/SH: `rsp_valid` in N+3;
  - faults: `rsp_valid` in N+1.
- `req_ready` is low from N+1 until the RESP cycle inclusive, and high again the cycle after RESP.
- Back-to-back throughput: one load every 3 cycles.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronously), including `mem_write` dropping within RMW_WR. The in-flight access is discarded with no response.
- A `req_valid` that drops before acceptance is ignored. No request is queued.

## Configuration
- `MIPS_LSU_ALIGN_TRAP_EN` defined:
  - LH, LHU or SH with `addr[0]`=1 faults with no memory access.
  - LW or SW with `addr[1:0]`≠0 faults with no memory access.
- Not defined: unaligned LW/SW pass `req_addr` straight to memory, which assembles bytes addr..addr+3. Unaligned halfwords use lane `addr[1]`, with `addr[0]` ignored. Only unsupported opcodes fault.

## Structure
- `mips_lsu_pkg` holds:
  - the opcode constants: LB=6'h20, LH=6'h21, LW=6'h23, LBU=6'h24, LHU=6'h25, SB=6'h28, SH=6'h29, SW=6'h2B;
  - the FSM state enum;
  - the word-width constant.
- One combinational sub-module, `mips_lsu_lane`, performs lane extract/extend for loads and lane merge for stores. The FSM stays in `mips_lsu`.

## Test plan
- Memory word 0x10 = 0x8899AABB; LB @0x11 → `rsp_rdata`=0xFFFFFFAA at N+2, `mem_write` never 1.
- Same word; LHU @0x12 → `rsp_rdata`=0x00008899 at N+2; LH @0x12 → 0xFFFF8899.
- SB @0x13, wdata 0x12345677 → `mem_read` 1 at N+1 with `mem_addr`=0x10, `mem_write` 1 at N+2 with `mem_wdata`=0x7799AABB, `rsp_valid` at N+3.
- SW @0x20, 0xDEADBEEF, then LW @0x20 → `rsp_rdata`=0xDEADBEEF. `req_ready`=0 for exactly two cycles after each acceptance.
- With `MIPS_LSU_ALIGN_TRAP_EN`, SW @0x22 → `rsp_fault`=1 at N+1, no `mem_write`. Without the macro, the same access writes bytes 0x22–0x25.
- Assert `rst_n`=0 during RMW_WR → `mem_write`=0 the same instant, no `rsp_valid`, `req_ready`=1 after release.
